stream_credit_tx: RTL and testbench

Credit-based stream transmitter placed on the producer side of a pipelined link that feeds a deep StreamingFIFO on the consumer side. The link's TREADY cannot travel back through the link registers, so this block tracks free space in the remote FIFO with a credit counter. It forwards 8-bit beats as valid-only pulses and accepts one credit-return pulse per word that the remote FIFO drains. The credit count mirrors the remote FIFO's free space, with a register-accurate relationship to the FIFO's count output.

---
 rtl/stream_credit_pkg.sv | 19 +
 rtl/stream_credit_tx_if.sv | 39 +++
 rtl/stream_skid2.sv | 73 +++++++
 rtl/stream_credit_tx.sv | 94 +++++++++
 tb/tb_stream_credit_tx.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/stream_credit_pkg.sv
// Shared types and constants for the credit-based stream transmitter.
// Contents: skid-buffer occupancy enum, credit-width helper, stall counter width.
package stream_credit_pkg;

    // Skid buffer fill level
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    localparam int unsigned STALL_W = 32;

    // Width needed to hold a credit value in 0..depth inclusive
    function automatic int unsigned credit_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stream_credit_tx_if.sv
// Handshake/bus bundle for stream_credit_tx.
// Upstream stream (in0_V_V_*), valid-only link (out_V_V_*), credit return path,
// credit status and, when STREAM_CREDIT_TX_STATS_EN is defined, stall_cycles.
// slave: the transmitter's view.  master: the environment's view.
interface stream_credit_tx_if
    import stream_credit_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CW    = 15
);
    logic [WIDTH-1:0] in0_V_V_TDATA;
    logic             in0_V_V_TVALID;
    logic             in0_V_V_TREADY;
    logic [WIDTH-1:0] out_V_V_TDATA;
    logic             out_V_V_TVALID;
    logic             credit_ret;
    logic [CW-1:0]    credits;
    logic             credit_err;
`ifdef STREAM_CREDIT_TX_STATS_EN
    logic [STALL_W-1:0] stall_cycles;
`endif

    modport slave (
        input  in0_V_V_TDATA, in0_V_V_TVALID, credit_ret,
        output in0_V_V_TREADY, out_V_V_TDATA, out_V_V_TVALID, credits, credit_err
`ifdef STREAM_CREDIT_TX_STATS_EN
        , output stall_cycles
`endif
    );

    modport master (
        output in0_V_V_TDATA, in0_V_V_TVALID, credit_ret,
        input  in0_V_V_TREADY, out_V_V_TDATA, out_V_V_TVALID, credits, credit_err
`ifdef STREAM_CREDIT_TX_STATS_EN
        , input stall_cycles
`endif
    );

endinterface

// File: rtl/stream_skid2.sv
// Two-entry FIFO-order skid buffer with registered ready.
// Ports: clk, rst_n (async active-low), in_data_i/in_valid_i/in_ready_o upstream,
// pop_i removes the head, head_o is the oldest entry, occ_o the fill level.
module stream_skid2
    import stream_credit_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output occ_e             occ_o
);

    occ_e             occ_q;
    logic             ready_q;
    logic [WIDTH-1:0] mem0_q;
    logic [WIDTH-1:0] mem1_q;
    logic             acc_c;

    assign acc_c = in_valid_i && ready_q;

    // Occupancy FSM; ready tracks whether the next occupancy is below FULL
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q   <= EMPTY;
            ready_q <= 1'b0;
            mem0_q  <= '0;
            mem1_q  <= '0;
        end else begin
            ready_q <= 1'b1;
            case (occ_q)
                EMPTY: begin
                    if (acc_c) begin
                        mem0_q <= in_data_i;
                        occ_q  <= ONE;
                    end
                end
                ONE: begin
                    case ({acc_c, pop_i})
                        2'b10: begin
                            mem1_q  <= in_data_i;
                            occ_q   <= FULL;
                            ready_q <= 1'b0;
                        end
                        2'b01:   occ_q  <= EMPTY;
                        2'b11:   mem0_q <= in_data_i;
                        default: ;
                    endcase
                end
                FULL: begin
                    // ready is low here, so only a pop can occur
                    if (pop_i) begin
                        mem0_q <= mem1_q;
                        occ_q  <= ONE;
                    end else begin
                        ready_q <= 1'b0;
                    end
                end
                default: occ_q <= EMPTY;
            endcase
        end
    end

    assign in_ready_o = ready_q;
    assign head_o     = mem0_q;
    assign occ_o      = occ_q;

endmodule

// File: rtl/stream_credit_tx.sv
// Credit-based stream transmitter: forwards beats as valid-only pulses while
// the remote FIFO has free space, tracked by a credit counter.
// Ports: ap_clk, ap_rst_n (async active-low), bus (stream_credit_tx_if.slave).
// Optional feature macro: STREAM_CREDIT_TX_STATS_EN adds bus.stall_cycles.
module stream_credit_tx
    import stream_credit_pkg::*;
#(
    parameter int unsigned DEPTH = 16384,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CW    = credit_w(DEPTH)
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    stream_credit_tx_if.slave bus
);

    localparam logic [CW-1:0] CRED_MAX = CW'(DEPTH);

    logic [WIDTH-1:0] head;
    occ_e             occ;
    logic             send_c;
    logic [CW-1:0]    credits_q, credits_d;
    logic             err_q, err_d;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;

    stream_skid2 #(.WIDTH(WIDTH)) u_skid (
        .clk        (ap_clk),
        .rst_n      (ap_rst_n),
        .in_data_i  (bus.in0_V_V_TDATA),
        .in_valid_i (bus.in0_V_V_TVALID),
        .in_ready_o (bus.in0_V_V_TREADY),
        .pop_i      (send_c),
        .head_o     (head),
        .occ_o      (occ)
    );

    // Registered occupancy means a beat accepted this cycle cannot leave this cycle
    assign send_c = (occ != EMPTY) && (credits_q != '0);

    // Credit update; a return while already full saturates and flags the error
    always_comb begin
        credits_d = credits_q;
        err_d     = err_q;
        case ({send_c, bus.credit_ret})
            2'b10: credits_d = credits_q - CW'(1);
            2'b01: begin
                if (credits_q == CRED_MAX) begin
                    err_d = 1'b1;
                end else begin
                    credits_d = credits_q + CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            credits_q   <= CRED_MAX;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            credits_q   <= credits_d;
            err_q       <= err_d;
            out_valid_q <= send_c;
            if (send_c) begin
                out_data_q <= head;
            end
        end
    end

    assign bus.out_V_V_TVALID = out_valid_q;
    assign bus.out_V_V_TDATA  = out_data_q;
    assign bus.credits        = credits_q;
    assign bus.credit_err     = err_q;

`ifdef STREAM_CREDIT_TX_STATS_EN
    logic [STALL_W-1:0] stall_q;

    // Count cycles where data waits for credit; saturating
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            stall_q <= '0;
        end else if ((occ != EMPTY) && (credits_q == '0) && (stall_q != '1)) begin
            stall_q <= stall_q + STALL_W'(1);
        end
    end

    assign bus.stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_stream_credit_tx.sv
// Self-checking bench for stream_credit_tx at DEPTH=4.
module tb_stream_credit_tx;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned CW    = 3;

    logic ap_clk = 1'b0;
    logic ap_rst_n = 1'b0;

    always #5 ap_clk = ~ap_clk;

    stream_credit_tx_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

    stream_credit_tx #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus)
    );

    typedef struct {
        bit       rst;
        bit       v;
        bit [7:0] d;
        bit       cr;
        bit       rdy;
        bit       ov;
        int       crd;
        bit       err;
        int       stall;
    } vec_t;

    vec_t     vecs[$];
    bit [7:0] sb[$];
    int       n_tests = 0;
    int       n_fail  = 0;

    function automatic vec_t mk(bit rst, bit v, bit [7:0] d, bit cr,
                                bit rdy, bit ov, int crd, bit err, int stall);
        vec_t r;
        r.rst = rst; r.v = v; r.d = d; r.cr = cr;
        r.rdy = rdy; r.ov = ov; r.crd = crd; r.err = err; r.stall = stall;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.in0_V_V_TVALID = 1'b0;
        bus.in0_V_V_TDATA  = '0;
        bus.credit_ret     = 1'b0;
    endtask

    // Hold reset for two cycles, check reset values, release at a falling edge
    task automatic do_reset();
        drive_idle();
        ap_rst_n = 1'b0;
        sb.delete();
        repeat (2) @(negedge ap_clk);
        check("rst_ready", 32'(bus.in0_V_V_TREADY), 0);
        check("rst_ovalid", 32'(bus.out_V_V_TVALID), 0);
        check("rst_odata", 32'(bus.out_V_V_TDATA), 0);
        check("rst_credits", 32'(bus.credits), DEPTH);
        check("rst_err", 32'(bus.credit_err), 0);
`ifdef STREAM_CREDIT_TX_STATS_EN
        check("rst_stall", bus.stall_cycles, 0);
`endif
        ap_rst_n = 1'b1;
    endtask

    // Scoreboard: each link pulse must carry the oldest accepted, unsent beat
    always @(negedge ap_clk) begin
        if (ap_rst_n && bus.out_V_V_TVALID === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: pulse with data %0h, required no pulse", bus.out_V_V_TDATA);
            end else begin
                check("sb_data", 32'(bus.out_V_V_TDATA), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        drive_idle();

        // Back-to-back stream of three beats
        vecs.push_back(mk(1, 0, 8'h00, 0, 1, 0, 4, 0, 0));
        vecs.push_back(mk(0, 1, 8'h11, 0, 1, 0, 4, 0, 0));
        vecs.push_back(mk(0, 1, 8'h22, 0, 1, 1, 3, 0, 0));
        vecs.push_back(mk(0, 1, 8'h33, 0, 1, 1, 2, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 1, 0, 0));
        // Exhaust credits, fill buffer, ready drops
        vecs.push_back(mk(1, 0, 8'h00, 0, 1, 0, 4, 0, 0));
        vecs.push_back(mk(0, 1, 8'hA1, 0, 1, 0, 4, 0, 0));
        vecs.push_back(mk(0, 1, 8'hA2, 0, 1, 1, 3, 0, 0));
        vecs.push_back(mk(0, 1, 8'hA3, 0, 1, 1, 2, 0, 0));
        vecs.push_back(mk(0, 1, 8'hA4, 0, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'hA5, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'hA6, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 8'hA7, 0, 0, 0, 0, 0, 2));
        // Single credit return releases exactly one beat one cycle later
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 0, 3));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1, 0, 0, 3));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0, 0, 4));
        // Return credits to reach 2
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 1, 0, 5));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 1, 0, 5));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 2, 0, 5));
        // Steady state: send and return every cycle, credits hold at 2
        vecs.push_back(mk(0, 1, 8'hC1, 0, 1, 0, 2, 0, 5));
        vecs.push_back(mk(0, 1, 8'hC2, 1, 1, 1, 2, 0, 5));
        vecs.push_back(mk(0, 1, 8'hC3, 1, 1, 1, 2, 0, 5));
        vecs.push_back(mk(0, 1, 8'hC4, 1, 1, 1, 2, 0, 5));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 2, 0, 5));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 2, 0, 5));
        // Refill to DEPTH then overflow: sticky error, credits saturate
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 3, 0, 5));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 4, 0, 5));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 4, 1, 5));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 4, 1, 5));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 4, 1, 5));
        // Prepare two buffered beats with credits=1
        vecs.push_back(mk(1, 0, 8'h00, 0, 1, 0, 4, 0, 0));
        vecs.push_back(mk(0, 1, 8'hF1, 0, 1, 0, 4, 0, 0));
        vecs.push_back(mk(0, 1, 8'hF2, 0, 1, 1, 3, 0, 0));
        vecs.push_back(mk(0, 1, 8'hF3, 0, 1, 1, 2, 0, 0));
        vecs.push_back(mk(0, 1, 8'hF4, 0, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'hF5, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'hF6, 1, 0, 0, 1, 0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            bus.in0_V_V_TVALID = vecs[i].v;
            bus.in0_V_V_TDATA  = vecs[i].d;
            bus.credit_ret     = vecs[i].cr;
            if (vecs[i].v && bus.in0_V_V_TREADY) sb.push_back(vecs[i].d);
            @(posedge ap_clk);
            @(negedge ap_clk);
            check($sformatf("row%0d_ready", i), 32'(bus.in0_V_V_TREADY), 32'(vecs[i].rdy));
            check($sformatf("row%0d_ovalid", i), 32'(bus.out_V_V_TVALID), 32'(vecs[i].ov));
            check($sformatf("row%0d_credits", i), 32'(bus.credits), 32'(vecs[i].crd));
            check($sformatf("row%0d_err", i), 32'(bus.credit_err), 32'(vecs[i].err));
`ifdef STREAM_CREDIT_TX_STATS_EN
            check($sformatf("row%0d_stall", i), bus.stall_cycles, 32'(vecs[i].stall));
`endif
        end

        // Asynchronous reset mid-cycle with beats buffered: immediate clear
        drive_idle();
        #2;
        ap_rst_n = 1'b0;
        sb.delete();
        #1;
        check("async_ready", 32'(bus.in0_V_V_TREADY), 0);
        check("async_ovalid", 32'(bus.out_V_V_TVALID), 0);
        check("async_odata", 32'(bus.out_V_V_TDATA), 0);
        check("async_credits", 32'(bus.credits), DEPTH);
        check("async_err", 32'(bus.credit_err), 0);
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        // Discarded beats must never appear on the link
        for (int k = 0; k < 4; k++) begin
            @(posedge ap_clk);
            @(negedge ap_clk);
            check($sformatf("post_rst%0d_ovalid", k), 32'(bus.out_V_V_TVALID), 0);
            check($sformatf("post_rst%0d_credits", k), 32'(bus.credits), DEPTH);
            check($sformatf("post_rst%0d_ready", k), 32'(bus.in0_V_V_TREADY), 1);
        end

        check("sb_drained", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
